fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Fetch sequencer for the 16-bit word instruction memory (registered read, 1-cycle latency).
//  Owns the PC and drives the memory address. Captures returned words into a 2-entry buffer.
//  Presents {instr, pc} to decode with a valid/ready handshake.
//  Applies branch/jump redirects from execute, plus pause and out-of-range fault handling.
// PARAMETERS
//  RESET_PC   16'd0   PC loaded on reset
//  PC_STEP    16'd2   PC increment per instruction (memory holds instructions at even addresses)
//  MEM_WORDS  16'd20  first illegal fetch address; pc >= MEM_WORDS raises fault
// PORTS
//  clk              in   1   single clock, all state updates on posedge
//  reset            in   1   synchronous, active-high
//  imem_addr        out  16  address to instruction memory (= pc, combinational)
//  imem_rdata       in   16  memory output; valid the cycle after imem_addr is sampled
//  instr_out        out  16  buffer head instruction
//  instr_pc         out  16  PC of instr_out
//  instr_valid      out  1   buffer non-empty
//  instr_ready      in   1   decode accepts head this cycle (pop = valid & ready)
//  redirect_valid   in   1   one-cycle redirect request (taken bne / jump)
//  redirect_target  in   16  new PC; bit0 ignored, forced 0
//  halt_req         in   1   level: stop issuing new fetches
//  fetch_fault      out  1   sticky: pc reached MEM_WORDS
// BEHAVIOUR
//  Reset (reset=1 at posedge): pc=RESET_PC, buffer empty, inflight=0, state=IDLE.
//   Outputs after reset: instr_valid=0, instr_out=0, instr_pc=0, fetch_fault=0, imem_addr=RESET_PC.
//  FSM: IDLE -> RUN unconditionally, one cycle after reset deasserts.
//   RUN -> PAUSE: halt_req=1.
//   PAUSE -> RUN: halt_req=0.
//   RUN -> FAULT: issue would occur with pc >= MEM_WORDS.
//   FAULT -> RUN: only on redirect_valid, or via reset.
//  Issue (address sampled by memory), only in RUN:
//   Condition: !redirect_valid & pc < MEM_WORDS & (count + inflight - pop) < 2.
//   On issue: inflight<=1, ifpc<=pc, pc<=pc+PC_STEP (mod 2^16).
//   The pop term is combinational from instr_ready, giving a sustained 1 instr/cycle.
//  Capture: in a cycle with inflight=1 and no redirect, push {imem_rdata, ifpc} at tail.
//   inflight<=issue. Buffer can never overflow; overflow is an assertion failure.
//  Pop: head advances; capture and pop in the same cycle are both honoured.
//  Redirect (highest priority, any state except IDLE):
//   pc<=target&~1, buffer cleared, inflight cleared; memory data arriving next cycle is discarded.
//   No issue in the redirect cycle. fetch_fault cleared. State -> RUN (PAUSE if halt_req=1).
//  Latency:
//   First reset-low cycle C0 (IDLE). C1 issues RESET_PC. C2 captures. C3 instr_valid=1.
//   Redirect in cycle R: first new instr valid at R+3.
//  PAUSE: in-flight word still captured; buffer still drains; imem_addr holds pc.
//  FAULT: fetch_fault=1 and held; no issue; buffered entries drain normally; imem_addr holds pc.
//  Outputs while decode stalls (valid & !ready): instr_out/instr_pc are stable.
//  Reset mid-operation: buffer and in-flight discarded; no stale word ever becomes valid.
// TESTING (bench pairs block with a registered-read 16-bit instruction memory; words preloaded at 0..18)
//  1 Reset, ready=1 -> instr_valid rises in C3; instr_pc = 0,2,4,...,18 on consecutive cycles.
//    instr_out matches the preloaded words.
//  2 ready=0 for 5 cycles after pc0 is valid -> instr_pc held at 0, at most 2 buffered.
//    After release: 0,2,4... contiguous, none lost or duplicated.
//  3 redirect 16'h0008 while buffer full (pcs 4,6) -> instr_valid=0 next cycle.
//    Next valid instr_pc=8 at R+3; pcs 4/6 never reappear. Target 16'h0009 behaves identically.
//  4 Free run with MEM_WORDS=20 -> after pc18 is accepted: fetch_fault=1, instr_valid=0, imem_addr=20.
//    Then redirect to 0 -> fault clears, pc0 valid at R+3.
//  5 halt_req=1 for 4 cycles mid-stream -> in-flight word still delivered, no new addresses.
//    After release, sequence resumes without gap or duplicate.
//  6 reset pulse with 2 buffered and 1 in flight -> instr_valid=0 next cycle.
//    Restart from RESET_PC at C3; redirect coinciding with pop+capture -> redirect wins.

Source files
------------

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer with 2-entry buffer, redirect, pause and fault
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'd0,
    parameter logic [15:0] PC_STEP   = 16'd2,
    parameter logic [15:0] MEM_WORDS = 16'd20
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    input  logic        halt_req,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ifpc;
    logic        inflight;

    logic [15:0] buf_instr [2];
    logic [15:0] buf_pc    [2];
    logic        head;
    logic [1:0]  count;

    logic        pop;
    logic        redirect;
    logic        pc_legal;
    logic [1:0]  occupancy;
    logic        has_room;
    logic        issue;
    logic        fault_hit;
    logic        push;
    logic        tail;

    // Redirects are ignored only during the single IDLE cycle after reset.
    assign pop       = instr_valid & instr_ready;
    assign redirect  = redirect_valid & (state != S_IDLE);
    assign pc_legal  = pc < MEM_WORDS;
    // Slots that will be committed after this cycle: buffered + arriving - leaving.
    assign occupancy = count + {1'b0, inflight} - {1'b0, pop};
    assign has_room  = occupancy < 2'd2;
    assign issue     = (state == S_RUN) & !redirect & pc_legal & has_room;
    assign fault_hit = (state == S_RUN) & !redirect & !pc_legal & has_room;
    // A word in flight during a redirect belongs to the old path and is dropped.
    assign push      = inflight & !redirect;
    // Tail slot is head + count modulo 2; with count==2 only a push-with-pop reaches here.
    assign tail      = head ^ count[0];

    assign imem_addr   = pc;
    assign instr_valid = (count != 2'd0);
    assign instr_out   = buf_instr[head];
    assign instr_pc    = buf_pc[head];

    // Control FSM, program counter and in-flight tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            ifpc        <= RESET_PC;
            inflight    <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (redirect) begin
            pc          <= redirect_target & 16'hFFFE;
            inflight    <= 1'b0;
            fetch_fault <= 1'b0;
            state       <= halt_req ? S_PAUSE : S_RUN;
        end else begin
            inflight <= issue;
            if (issue) begin
                ifpc <= pc;
                pc   <= pc + PC_STEP;
            end
            case (state)
                S_IDLE:  state <= S_RUN;
                S_RUN: begin
                    if (halt_req) begin
                        state <= S_PAUSE;
                    end else if (fault_hit) begin
                        state       <= S_FAULT;
                        fetch_fault <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (!halt_req) state <= S_RUN;
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Two-entry instruction buffer; capture and pop may happen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            head         <= 1'b0;
            count        <= 2'd0;
            buf_instr[0] <= 16'd0;
            buf_instr[1] <= 16'd0;
            buf_pc[0]    <= 16'd0;
            buf_pc[1]    <= 16'd0;
        end else if (redirect) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                buf_instr[tail] <= imem_rdata;
                buf_pc[tail]    <= ifpc;
            end
            if (pop) head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // The issue rule reserves a slot for every fetch, so a push into a full buffer is a design bug.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && count == 2'd2));
        end
    end

endmodule
